// File: rtl/button_debouncer_array.sv
// N-channel push-button front end: 2-flop synchroniser, shared sample-tick prescaler,
// per-channel debounce and a hold FSM producing press/release/long/repeat pulses.
module button_debouncer_array #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int REPEAT_EN    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             sample_tick
);

  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam int SW = $clog2(STABLE_TICKS) + 1;
  localparam int HW = $clog2(LONG_TICKS) + 1;
  localparam int RW = $clog2(REPEAT_TICKS) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } hold_state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [TW-1:0]    r_tick_cnt;
  logic             r_sample_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The tick is registered one count early so it is high while the counter sits at TICK_DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt    <= '0;
      r_sample_tick <= 1'b0;
    end else begin
      r_tick_cnt    <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
      r_sample_tick <= (r_tick_cnt == TICK_PRE);
    end
  end

  assign sample_tick = r_sample_tick;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    hold_state_t   r_state;
    logic [SW-1:0] r_stab_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [RW-1:0] r_rep_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_repeat;
    logic          w_differs;
    logic          w_flip;

    assign w_differs = (r_sync2[g] != r_level);
    assign w_flip    = w_differs && (r_stab_cnt == STAB_LAST);

    // A debounced fall is checked before the hold thresholds, so release beats long/repeat.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state    <= S_IDLE;
        r_stab_cnt <= '0;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
        r_level    <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        if (r_sample_tick) begin
          if (w_flip) begin
            r_level    <= ~r_level;
            r_stab_cnt <= '0;
            r_press    <= ~r_level;
            r_release  <= r_level;
          end else if (w_differs) begin
            r_stab_cnt <= r_stab_cnt + SW'(1);
          end else begin
            r_stab_cnt <= '0;
          end

          case (r_state)
            S_IDLE: begin
              if (w_flip && !r_level) begin
                r_state    <= S_HELD;
                r_hold_cnt <= '0;
              end
            end
            S_HELD: begin
              if (w_flip) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
              end else if (r_hold_cnt == HOLD_LAST) begin
                r_long     <= 1'b1;
                r_state    <= S_LONG;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
              end
            end
            S_LONG: begin
              if (w_flip) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
              end else if (r_rep_cnt == REP_LAST) begin
                r_repeat  <= REP_ON;
                r_rep_cnt <= '0;
              end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
              end
            end
            default: begin
              r_state    <= S_IDLE;
              r_hold_cnt <= '0;
              r_rep_cnt  <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_long[g]    = r_long;
    assign btn_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_button_debouncer_array.sv
// Bench for button_debouncer_array: tick-level behavioural model feeding an expected queue,
// per-cycle comparison of two instances (repeat on/off) and hand-timed event checks.
module tb_button_debouncer_array;
  localparam int N    = 2;
  localparam int TDIV = 4;
  localparam int STAB = 3;
  localparam int LONG = 8;
  localparam int REP  = 2;
  localparam int W    = 5 * N + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_raw = '0;

  logic [N-1:0] a_level, a_press, a_release, a_long, a_repeat;
  logic         a_tick;
  logic [N-1:0] b_level, b_press, b_release, b_long, b_repeat;
  logic         b_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  button_debouncer_array #(
    .N_BTN(N), .TICK_DIV(TDIV), .STABLE_TICKS(STAB),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .REPEAT_EN(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(a_level), .btn_press(a_press), .btn_release(a_release),
    .btn_long(a_long), .btn_repeat(a_repeat), .sample_tick(a_tick)
  );

  button_debouncer_array #(
    .N_BTN(N), .TICK_DIV(TDIV), .STABLE_TICKS(STAB),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .REPEAT_EN(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
    .btn_level(b_level), .btn_press(b_press), .btn_release(b_release),
    .btn_long(b_long), .btn_repeat(b_repeat), .sample_tick(b_tick)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // behavioural model: works per tick with plain integers (run length, ticks held)
  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_sync1 = '0, m_sync2 = '0, m_lvl = '0;
  logic [N-1:0] m_p, m_r, m_l, m_rp;
  int           m_run[N];
  int           m_held[N];
  bit           m_holding[N];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync1 = '0;
      m_sync2 = '0;
      m_lvl   = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_held[i] = 0; m_holding[i] = 1'b0;
      end
      exp_q.delete();
    end else begin
      m_p = '0; m_r = '0; m_l = '0; m_rp = '0;
      if (cyc % TDIV == TDIV - 1) begin
        for (int i = 0; i < N; i++) begin
          if (m_sync2[i] != m_lvl[i]) m_run[i]++;
          else                        m_run[i] = 0;
          if (m_run[i] == STAB) begin
            m_run[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) begin
              m_p[i] = 1'b1; m_holding[i] = 1'b1; m_held[i] = 0;
            end else begin
              m_r[i] = 1'b1; m_holding[i] = 1'b0;
            end
          end else if (m_holding[i]) begin
            m_held[i]++;
            if (m_held[i] == LONG) m_l[i] = 1'b1;
            else if (m_held[i] > LONG && (m_held[i] - LONG) % REP == 0) m_rp[i] = 1'b1;
          end
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = btn_raw;
      exp_q.push_back({m_lvl, m_p, m_r, m_l, m_rp, ((cyc + 1) % TDIV == TDIV - 1)});
    end
  end

  // scoreboard / event log
  logic [W-1:0] cmp_e;
  int press_cnt[N], press_cyc[N], rel_cnt[N], rel_cyc[N];
  int long_cnt[N], long_cyc[N], rep_cnt[N], rep_cyc[N], b_long_cnt[N], b_rep_cnt[N];
  int tick_seen = 0;
  int tick_cyc[2];

  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; press_cyc[i] = -1; rel_cnt[i] = 0; rel_cyc[i] = -1;
      long_cnt[i] = 0; long_cyc[i] = -1; rep_cnt[i] = 0; rep_cyc[i] = -1;
      b_long_cnt[i] = 0; b_rep_cnt[i] = 0;
    end
    tick_cyc[0] = -1;
    tick_cyc[1] = -1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      cmp_e = '0;
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_empty at cycle %0d: got empty queue expected one entry", cyc);
      cmp_e = '0;
    end else begin
      cmp_e = exp_q.pop_front();
    end
    chk("a_level",   32'(a_level),   32'(cmp_e[4*N+1 +: N]));
    chk("a_press",   32'(a_press),   32'(cmp_e[3*N+1 +: N]));
    chk("a_release", 32'(a_release), 32'(cmp_e[2*N+1 +: N]));
    chk("a_long",    32'(a_long),    32'(cmp_e[N+1 +: N]));
    chk("a_repeat",  32'(a_repeat),  32'(cmp_e[1 +: N]));
    chk("a_tick",    32'(a_tick),    32'(cmp_e[0]));
    chk("b_level",   32'(b_level),   32'(cmp_e[4*N+1 +: N]));
    chk("b_press",   32'(b_press),   32'(cmp_e[3*N+1 +: N]));
    chk("b_release", 32'(b_release), 32'(cmp_e[2*N+1 +: N]));
    chk("b_long",    32'(b_long),    32'(cmp_e[N+1 +: N]));
    chk("b_repeat",  32'(b_repeat),  32'd0);
    chk("b_tick",    32'(b_tick),    32'(cmp_e[0]));
    if (reset_n) begin
      if (a_tick && tick_seen < 2) begin
        tick_cyc[tick_seen] = cyc;
        tick_seen++;
      end
      for (int i = 0; i < N; i++) begin
        if (a_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
        if (a_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
        if (a_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
        if (a_repeat[i])  begin rep_cnt[i]++;   rep_cyc[i]   = cyc; end
        if (b_long[i])    b_long_cnt[i]++;
        if (b_repeat[i])  b_rep_cnt[i]++;
      end
    end
  end

  // driver tasks
  task automatic go_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL go_cycle_timeout: got cycle %0d expected %0d", cyc, c);
    end
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs_a", 32'({a_level, a_press, a_release, a_long, a_repeat, a_tick}), 32'd0);
    chk("rst_outputs_b", 32'({b_level, b_press, b_release, b_long, b_repeat, b_tick}), 32'd0);
    btn_raw = 2'b00;
    @(negedge clk);
    #1 reset_n = 1'b1;

    // clean press on ch0, then hold for 20 ticks
    go_cycle(20);  btn_raw = 2'b01;
    go_cycle(40);
    chk("first_tick",     32'(tick_cyc[0]), 32'd3);
    chk("second_tick",    32'(tick_cyc[1]), 32'd7);
    chk("press0_cycle",   32'(press_cyc[0]), 32'd32);
    chk("press0_count",   32'(press_cnt[0]), 32'd1);
    chk("press1_quiet",   32'(press_cnt[1]), 32'd0);
    go_cycle(112); btn_raw = 2'b00;
    go_cycle(128);
    chk("long0_cycle",    32'(long_cyc[0]), 32'd64);
    chk("long0_count",    32'(long_cnt[0]), 32'd1);
    chk("repeat0_count",  32'(rep_cnt[0]),  32'd7);
    chk("repeat0_last",   32'(rep_cyc[0]),  32'd120);
    chk("release0_cycle", 32'(rel_cyc[0]),  32'd124);
    chk("b_long0_count",  32'(b_long_cnt[0]), 32'd1);
    chk("b_repeat0_count",32'(b_rep_cnt[0]),  32'd0);

    // glitches: 2 high ticks; then 2 high, 1 low, 3 high
    btn_raw = 2'b01;
    go_cycle(136); btn_raw = 2'b00;
    go_cycle(144); btn_raw = 2'b01;
    go_cycle(152); btn_raw = 2'b00;
    go_cycle(156); btn_raw = 2'b01;
    go_cycle(172); btn_raw = 2'b00;
    chk("glitch_press_count", 32'(press_cnt[0]), 32'd2);
    chk("glitch_press_cycle", 32'(press_cyc[0]), 32'd168);
    go_cycle(190);
    chk("glitch_release_cycle", 32'(rel_cyc[0]), 32'd184);

    // simultaneous press; ch0 falls exactly on its 8th hold tick
    go_cycle(192); btn_raw = 2'b11;
    go_cycle(224); btn_raw = 2'b10;
    go_cycle(248); btn_raw = 2'b00;
    go_cycle(264);
    chk("simul_press0",    32'(press_cyc[0]), 32'd204);
    chk("simul_press1",    32'(press_cyc[1]), 32'd204);
    chk("coinc_release0",  32'(rel_cyc[0]),   32'd236);
    chk("coinc_no_long0",  32'(long_cnt[0]),  32'd1);
    chk("ch1_long_cycle",  32'(long_cyc[1]),  32'd236);
    chk("ch1_repeat_count",32'(rep_cnt[1]),   32'd2);
    chk("ch1_release",     32'(rel_cyc[1]),   32'd260);

    // reset at hold tick 5, raw kept high
    btn_raw = 2'b01;
    go_cycle(296);
    chk("pre_reset_presses", 32'(press_cnt[0]), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("reset_imm_level", 32'(a_level), 32'd0);
    chk("reset_imm_all",   32'({a_press, a_release, a_long, a_repeat, a_tick}), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    go_cycle(14);
    chk("fresh_press_count", 32'(press_cnt[0]), 32'd5);
    chk("fresh_press_cycle", 32'(press_cyc[0]), 32'd12);
    go_cycle(40);
    chk("no_stale_long",     32'(long_cnt[0]), 32'd1);
    go_cycle(48);
    chk("fresh_long_cycle",  32'(long_cyc[0]), 32'd44);
    btn_raw = 2'b00;
    go_cycle(70);
    chk("final_release",     32'(rel_cyc[0]), 32'd60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
